// File: rtl/feature_mem_pkg.sv
// feature_mem_pkg: shared FSM states, bank count and default sizing for the feature memory controller
package feature_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;
  localparam int NUM_BANKS = 4;
  localparam int DEF_DIV_SIZE = 512;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
endpackage

// File: rtl/feature_row_fifo.sv
// feature_row_fifo: 2-entry row FIFO with empty bypass (push/din in, pop, valid/dout/count out)
module feature_row_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, store, take;
  assign valid = count != 0 || push;
  assign dout = count != 0 ? mem[rp] : push ? din : '0;
  assign store = push && !(count == 0 && pop);
  assign take = pop && count != 0;
  always_ff @(posedge clk)
    if (store) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (store) wp <= !wp;
      if (take) rp <= !rp;
      count <= count + 2'(store) - 2'(take);
    end
endmodule

// File: rtl/feature_mem_ctrl.sv
// feature_mem_ctrl: loads one sample into a 4-bank memory (in_* -> mem_we/addr/wdata) then streams 4-word rows (mem_re/rdata -> row_*), with busy/load_done/done status
module feature_mem_ctrl
  import feature_mem_pkg::*;
#(
  parameter int DIV_SIZE   = DEF_DIV_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic [NUM_BANKS-1:0]            mem_we,
  output logic                            mem_re,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] row_data,
  output logic [ADDR_WIDTH-1:0]           row_index,
  output logic                            row_last,
  output logic                            busy,
  output logic                            load_done,
  output logic                            done
);
  localparam int ROWS = DIV_SIZE / NUM_BANKS;
  localparam int WW = $clog2(DIV_SIZE + 1);
  localparam int RW = $clog2(ROWS + 1);
  state_t state, state_n;
  logic [WW-1:0] wc;
  logic [RW-1:0] rc;
  logic [ADDR_WIDTH-1:0] tag;
  logic [1:0] occ;
  logic re_d, ld, accept, last_word, pop;
  assign in_ready = state == S_LOAD;
  assign accept = in_ready && in_valid;
  assign last_word = wc == WW'(DIV_SIZE - 1);
  assign mem_re = state == S_STREAM && rc < RW'(ROWS) && ({1'b0, occ} + {2'b0, re_d}) < 3'd2;
  assign mem_we = accept ? NUM_BANKS'(1) << wc[1:0] : '0;
  assign mem_addr = accept ? ADDR_WIDTH'(wc >> 2) : mem_re ? ADDR_WIDTH'(rc) : '0;
  assign mem_wdata = accept ? in_data : '0;
  assign pop = row_valid && row_ready;
  assign row_last = row_valid && row_index == ADDR_WIDTH'(ROWS - 1);
  assign busy = state != S_IDLE;
  assign load_done = ld;
  assign done = state == S_DONE;
  feature_row_fifo #(.W(NUM_BANKS * DATA_WIDTH + ADDR_WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (re_d),
    .din   ({tag, mem_rdata}),
    .pop   (pop),
    .valid (row_valid),
    .dout  ({row_index, row_data}),
    .count (occ)
  );
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE   ? (start ? S_LOAD : S_IDLE) :
              state == S_LOAD   ? (accept && last_word ? S_STREAM : S_LOAD) :
              state == S_STREAM ? (pop && row_last ? S_DONE : S_STREAM) : S_IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      wc <= '0;
      rc <= '0;
      tag <= '0;
      re_d <= 1'b0;
      ld <= 1'b0;
    end else begin
      state <= state_n;
      wc <= state == S_IDLE ? '0 : wc + WW'(accept);
      rc <= state == S_IDLE ? '0 : rc + RW'(mem_re);
      tag <= ADDR_WIDTH'(rc);
      re_d <= mem_re;
      ld <= accept && last_word;
    end
endmodule

// File: tb/tb_feature_mem_ctrl.sv
// tb_feature_mem_ctrl: randomized scoreboard bench for feature_mem_ctrl with a 4-bank memory model
module tb_feature_mem_ctrl;
  localparam int DS = 512, DW = 32, AW = 8, ROWS = DS / 4;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, row_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, mem_re, row_valid, row_last, busy, load_done, done;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_addr, row_index;
  logic [3:0] mem_we;
  logic [4*DW-1:0] mem_rdata, row_data;
  always #5 clk = ~clk;
  feature_mem_ctrl #(.DIV_SIZE(DS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_index(row_index), .row_last(row_last), .busy(busy),
    .load_done(load_done), .done(done)
  );
  logic [DW-1:0] bank [4][ROWS];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (mem_we[b]) bank[b][mem_addr[6:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= {bank[3][mem_addr[6:0]], bank[2][mem_addr[6:0]], bank[1][mem_addr[6:0]], bank[0][mem_addr[6:0]]};
  end
  logic [4+AW+DW-1:0] wq [$];
  logic [AW+4*DW-1:0] rq [$];
  logic [DW-1:0] words [DS];
  logic [AW+4*DW-1:0] prev_row;
  int vecs = 0, errs = 0, cyc = 0, issued = 0, popped = 0, rows_seen = 0;
  int ld_cnt = 0, done_cnt = 0, lw_cyc = 0, lp_cyc = 0, prev_pop = 0;
  bit exp_ld = 0, exp_done = 0, rr_rand = 0, prev_stall = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 row_ready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end
  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [AW+4*DW-1:0] er;
    if (reset) prev_stall = 0;
    else begin
      if (mem_we != 0 || mem_re) chk("we_re_exclusive", 192'(mem_we != 0 && mem_re), 192'(0));
      if (mem_we != 0) begin
        if (wq.size() == 0) chk("write_unexpected", 192'({mem_we, mem_addr, mem_wdata}), 192'(0));
        else begin
          chk("write", 192'({mem_we, mem_addr, mem_wdata}), 192'(wq.pop_front()));
          if (wq.size() == 0) begin exp_ld = 1; lw_cyc = cyc; end
        end
      end
      if (prev_stall) chk("stall_hold", 192'({row_valid, row_index, row_data}), 192'({1'b1, prev_row}));
      if (row_valid && row_ready) begin
        if (rq.size() == 0) chk("row_unexpected", 192'({1'b1, row_index, row_data}), 192'(0));
        else begin
          er = rq.pop_front();
          chk("row", 192'({row_last, row_index, row_data}), 192'({er[AW+4*DW-1 -: AW] == AW'(ROWS - 1), er}));
          if (!rr_rand && row_index != 0) chk("row_back2back", 192'(cyc), 192'(prev_pop + 1));
          prev_pop = cyc;
          rows_seen++;
          popped++;
          if (rq.size() == 0) begin exp_done = 1; lp_cyc = cyc; end
        end
      end
      if (mem_re) begin
        issued++;
        chk("outstanding", 192'(issued - popped <= 2), 192'(1));
      end
      if (load_done) begin
        chk("load_done", 192'({exp_ld, cyc}), 192'({1'b1, lw_cyc + 1}));
        exp_ld = 0;
        ld_cnt++;
      end
      if (done) begin
        chk("done", 192'({exp_done, cyc}), 192'({1'b1, lp_cyc + 1}));
        exp_done = 0;
        done_cnt++;
      end
      prev_stall = row_valid && !row_ready;
      prev_row = {row_index, row_data};
    end
  end
  task automatic check_zero(input string n);
    chk(n, 192'({in_ready, mem_we, mem_re, row_valid, row_last, busy, load_done, done,
                 mem_addr, mem_wdata, row_data, row_index}), 192'(0));
  endtask
  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    start = 0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk);
    #1 reset = 0;
    wq.delete();
    rq.delete();
    issued = 0;
    popped = 0;
    exp_ld = 0;
    exp_done = 0;
  endtask
  task automatic run_sample(input bit gaps, input bit rr, input bit seq, input bit poke,
                            input int abort_word, input int abort_row);
    int k, n;
    for (int i = 0; i < DS; i++) words[i] = seq ? DW'(i) : $urandom;
    wq.delete();
    rq.delete();
    for (int i = 0; i < DS; i++) wq.push_back({4'(1) << (i % 4), AW'(i / 4), words[i]});
    for (int r = 0; r < ROWS; r++) rq.push_back({AW'(r), words[4*r+3], words[4*r+2], words[4*r+1], words[4*r]});
    exp_ld = 0; exp_done = 0; ld_cnt = 0; done_cnt = 0;
    rows_seen = 0; issued = 0; popped = 0; rr_rand = rr;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    k = 0;
    n = 0;
    while (k < DS && k != abort_word && n < 20000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = words[k];
      start = poke && k == 100;
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1 n++;
    end
    in_valid = 0;
    start = 0;
    if (n >= 20000) chk("load_timeout", 192'(k), 192'(DS));
    if (k == abort_word) begin
      do_reset();
      chk("abort_load_pulses", 192'({ld_cnt, done_cnt}), 192'(0));
      return;
    end
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
    end
    n = 0;
    while (done_cnt == 0 && !(abort_row >= 0 && rows_seen >= abort_row) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (abort_row >= 0) begin
      do_reset();
      chk("abort_stream_pulses", 192'({ld_cnt, done_cnt}), 192'({32'd1, 32'd0}));
      return;
    end
    if (n >= 5000) chk("done_timeout", 192'(done_cnt), 192'(1));
    @(negedge clk);
    chk("idle_after_done", 192'({busy, in_ready}), 192'(0));
    chk("drained", 192'({wq.size(), rq.size()}), 192'(0));
    chk("pulse_counts", 192'({ld_cnt, done_cnt}), 192'({32'd1, 32'd1}));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk);
    #1 reset = 0;
    run_sample(0, 0, 1, 0, -1, -1);
    run_sample(1, 0, 0, 1, -1, -1);
    run_sample(1, 1, 0, 0, -1, -1);
    run_sample(1, 1, 0, 0, 200, -1);
    run_sample(0, 1, 0, 0, -1, 60);
    run_sample(1, 0, 0, 0, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
